sipo_deser: RTL and testbench

- Serial-to-parallel deserializer. Receiving end of the team's LSB-first serial shift link.
- Collects N serial bits, qualified by a per-bit strobe, into a word.
- Presents each completed word on a valid/ready output port with one word of holding buffer.
- Supports resynchronisation via a sync input and flags dropped words with a sticky overrun bit.

---
 rtl/sipo_deser.sv | 90 +++++++++
 tb/tb_sipo_deser.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// LSB-first serial-to-parallel deserializer with a one-word valid/ready holding
// register, sync-based word realignment and a sticky overrun flag.
module sipo_deser #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 serial_in,
   input  logic                 bit_valid,
   input  logic                 sync,
   input  logic                 clr_overrun,
   output logic [N-1:0]         parallel_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] bit_count,
   output logic                 overrun
);

   localparam int              CW   = $clog2(N);
   localparam logic [CW-1:0]   LAST = CW'(N - 1);

   logic [N-1:0]  shift_q, shift_d;
   logic [CW-1:0] count_q, count_d;
   logic [N-1:0]  data_q,  data_d;
   logic          valid_q, valid_d;
   logic          ovr_q,   ovr_d;

   logic [N-1:0]  word;
   logic          complete;
   logic          slot_free;

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
      shift_d   = shift_q;
      count_d   = count_q;
      data_d    = data_q;
      valid_d   = valid_q;
      ovr_d     = ovr_q;

      word      = {serial_in, shift_q[N-1:1]};
      complete  = bit_valid && !sync && (count_q == LAST);
      slot_free = !valid_q || out_ready;

      // sync realigns: a bit arriving with it becomes bit 0 of a fresh word
      if (sync) begin
         count_d = bit_valid ? CW'(1) : '0;
         shift_d = bit_valid ? {serial_in, {(N-1){1'b0}}} : '0;
      end else if (bit_valid) begin
         shift_d = word;
         count_d = complete ? '0 : count_q + 1'b1;
      end

      if (complete && slot_free) begin
         data_d  = word;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end

      // a new overrun event beats a clear in the same cycle
      if (complete && !slot_free) begin
         ovr_d = 1'b1;
      end else if (clr_overrun) begin
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and has priority; sequential state uses non-blocking assignments only.
      if (rst) begin
         shift_q <= '0;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign parallel_out = data_q;
   assign out_valid    = valid_q;
   assign bit_count    = count_q;
   assign overrun      = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: stimulus pushes expected words, a monitor
// pops and compares them on every output handshake.
module tb_sipo_deser;

   localparam int N = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 serial_in = 1'b0;
   logic                 bit_valid = 1'b0;
   logic                 sync = 1'b0;
   logic                 clr_overrun = 1'b0;
   logic                 out_ready = 1'b0;
   logic [N-1:0]         parallel_out;
   logic                 out_valid;
   logic [$clog2(N)-1:0] bit_count;
   logic                 overrun;

   int errors = 0;
   int checks = 0;
   logic [N-1:0] exp_q[$];

   sipo_deser #(.N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .bit_valid    (bit_valid),
      .sync         (sync),
      .clr_overrun  (clr_overrun),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .bit_count    (bit_count),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // one clock of stimulus; returns 1 time unit after the capturing edge
   task automatic cyc(input logic v, input logic b, input logic s);
      bit_valid = v;
      serial_in = b;
      sync      = s;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      serial_in = 1'b0;
      sync      = 1'b0;
   endtask

   task automatic send_word(input logic [N-1:0] w, input bit expect_out);
      if (expect_out) exp_q.push_back(w);
      for (int i = 0; i < N; i++) cyc(1'b1, w[i], 1'b0);
   endtask

   // monitor: every handshake must match the oldest expected word
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) check("unexpected word", {31'd0, out_valid}, 32'd0);
         else                   check("word", {28'd0, parallel_out}, {28'd0, exp_q.pop_front()});
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset bit_count", {30'd0, bit_count}, 32'd0);
      check("reset overrun", {31'd0, overrun}, 32'd0);
      check("reset parallel_out", {28'd0, parallel_out}, 32'd0);

      // basic: 1,0,1,1 -> 0xD one cycle after the last bit
      out_ready = 1'b1;
      send_word(4'hD, 1'b1);
      check("basic out_valid", {31'd0, out_valid}, 32'd1);
      check("basic parallel_out", {28'd0, parallel_out}, 32'hD);
      cyc(1'b0, 1'b0, 1'b0);
      check("basic valid drop", {31'd0, out_valid}, 32'd0);

      // gapped bits with bit_count observed during the gaps
      exp_q.push_back(4'hD);
      for (int i = 0; i < N; i++) begin
         cyc(1'b1, i != 1, 1'b0);
         if (i < N - 1) begin
            repeat (3) cyc(1'b0, 1'b0, 1'b0);
            check("gap bit_count", {30'd0, bit_count}, i + 1);
         end
      end
      cyc(1'b0, 1'b0, 1'b0);

      // stall: 0xA held, 0x5 dropped, overrun set
      out_ready = 1'b0;
      send_word(4'hA, 1'b1);
      send_word(4'h5, 1'b0);
      check("stall overrun", {31'd0, overrun}, 32'd1);
      check("stall parallel_out", {28'd0, parallel_out}, 32'hA);
      check("stall bit_count", {30'd0, bit_count}, 32'd0);
      out_ready = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      check("stall consumed", {31'd0, out_valid}, 32'd0);
      clr_overrun = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      clr_overrun = 1'b0;
      check("overrun cleared", {31'd0, overrun}, 32'd0);

      // overrun set and clear in the same cycle: set wins
      out_ready = 1'b0;
      send_word(4'h1, 1'b1);
      clr_overrun = 1'b1;
      send_word(4'h2, 1'b0);
      clr_overrun = 1'b0;
      check("set beats clear", {31'd0, overrun}, 32'd1);
      check("held word", {28'd0, parallel_out}, 32'h1);
      clr_overrun = 1'b1;
      out_ready   = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      clr_overrun = 1'b0;
      check("clear after set", {31'd0, overrun}, 32'd0);

      // streaming back-to-back words
      send_word(4'h3, 1'b1);
      send_word(4'hC, 1'b1);
      send_word(4'hF, 1'b1);
      check("stream overrun", {31'd0, overrun}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0);

      // sync after 2 bits: 0 (with sync),1,1,0 -> 0x6
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      check("sync bit_count", {30'd0, bit_count}, 32'd1);
      exp_q.push_back(4'h6);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // sync in the completion cycle suppresses the word: 1,1,0,1 -> 0xB
      for (int i = 0; i < N - 1; i++) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      check("sync suppress valid", {31'd0, out_valid}, 32'd0);
      check("sync suppress count", {30'd0, bit_count}, 32'd1);
      exp_q.push_back(4'hB);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);

      // reset mid-word with a pending word and overrun set
      out_ready = 1'b0;
      send_word(4'h3, 1'b1);
      send_word(4'h7, 1'b0);
      check("pre-reset overrun", {31'd0, overrun}, 32'd1);
      for (int i = 0; i < N - 1; i++) cyc(1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      exp_q.delete();
      check("mid reset out_valid", {31'd0, out_valid}, 32'd0);
      check("mid reset bit_count", {30'd0, bit_count}, 32'd0);
      check("mid reset overrun", {31'd0, overrun}, 32'd0);
      out_ready = 1'b1;
      send_word(4'h9, 1'b1);
      check("post reset word", {28'd0, parallel_out}, 32'h9);

      // drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1'b0, 1'b0, 1'b0);
      check("scoreboard drained", exp_q.size(), 32'd0);
      cyc(1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
